// File: rtl/ir_rx_pkg.sv
// Shared widths, constants and FSM state encoding for the IR pulse capture block.
package ir_rx_pkg;
    localparam int DUR_W   = 15;
    localparam int ENTRY_W = 16;

    localparam logic [ENTRY_W-1:0] TERMINATOR = 16'h0000;
    localparam logic [DUR_W-1:0]   DUR_SAT    = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;
endpackage

// File: rtl/ir_rx_fifo.sv
// First-word-fall-through FIFO; head shows the oldest entry whenever not empty.
module ir_rx_fifo
    import ir_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/ir_pulse_capture.sv
// IR receiver pulse-width capture: times mark/space intervals into a FWFT FIFO.
// Optional glitch filter enabled by defining IR_RX_GLITCH_FILTER_EN.
module ir_pulse_capture
    import ir_rx_pkg::*;
#(
    parameter int TICK_DIV      = 80,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_TICKS = 2000
) (
    input  logic        clock_in,
    input  logic        resetn_in,
    input  logic        enable_in,
    input  logic        ir_in,
    output logic [15:0] data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        busy_out,
    output logic        frame_end_out,
    output logic        overflow_out
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic               sync1;
    logic               sync2;
    logic               level;
    state_t             state;
    logic [PW-1:0]      prescale;
    logic [DUR_W-1:0]   count;
    logic [DUR_W-1:0]   count_next;
    logic               tick;
    logic               term_pending;
    logic               push;
    logic [ENTRY_W-1:0] push_data;
    logic               frame_end;
    logic               overflow;
    logic               full;
    logic               empty;

    always_ff @(posedge clock_in) begin
        if (!resetn_in) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
        end
    end

`ifdef IR_RX_GLITCH_FILTER_EN
    // New level wins only when it matches the three previous samples.
    logic [2:0] hist;
    logic       level_q;

    assign level = (hist == {3{sync2}}) ? sync2 : level_q;

    always_ff @(posedge clock_in) begin
        if (!resetn_in) begin
            hist    <= 3'b111;
            level_q <= 1'b1;
        end else begin
            hist    <= {hist[1:0], sync2};
            level_q <= level;
        end
    end
`else
    assign level = sync2;
`endif

    // Duration as it stands including a wrap on this very edge, so pushed value is floor(cycles/TICK_DIV).
    assign tick = (prescale == PW'(TICK_DIV - 1));

    always_comb begin
        count_next = count;
        if (tick && (count != DUR_SAT)) count_next = count + 1'b1;
    end

    always_ff @(posedge clock_in) begin
        if (!resetn_in) begin
            state        <= IDLE;
            prescale     <= '0;
            count        <= '0;
            term_pending <= 1'b0;
            push         <= 1'b0;
            push_data    <= '0;
            frame_end    <= 1'b0;
        end else begin
            push      <= 1'b0;
            frame_end <= 1'b0;
            prescale  <= tick ? '0 : prescale + 1'b1;
            count     <= count_next;
            if (term_pending) begin
                push         <= 1'b1;
                push_data    <= TERMINATOR;
                frame_end    <= 1'b1;
                term_pending <= 1'b0;
            end
            if (!enable_in) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!level) begin
                            state    <= MARK;
                            prescale <= '0;
                            count    <= '0;
                        end
                    end
                    MARK: begin
                        if (level) begin
                            push      <= 1'b1;
                            push_data <= {1'b1, count_next};
                            state     <= SPACE;
                            prescale  <= '0;
                            count     <= '0;
                        end
                    end
                    SPACE: begin
                        if (count_next == DUR_W'(TIMEOUT_TICKS)) begin
                            push         <= 1'b1;
                            push_data    <= {1'b0, count_next};
                            term_pending <= 1'b1;
                            state        <= IDLE;
                        end else if (!level) begin
                            push      <= 1'b1;
                            push_data <= {1'b0, count_next};
                            state     <= MARK;
                            prescale  <= '0;
                            count     <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (!resetn_in) begin
            overflow <= 1'b0;
        end else if (push && full && !(ready_in && !empty)) begin
            overflow <= 1'b1;
        end
    end

    ir_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock_in),
        .resetn    (resetn_in),
        .push      (push),
        .push_data (push_data),
        .pop       (ready_in),
        .head      (data_out),
        .full      (full),
        .empty     (empty)
    );

    assign valid_out     = !empty;
    assign busy_out      = (state != IDLE);
    assign frame_end_out = frame_end;
    assign overflow_out  = overflow;
endmodule

// File: tb/tb_ir_pulse_capture.sv
// Directed bench for ir_pulse_capture: three instances share stimulus, each checked where its parameters matter.
module tb_ir_pulse_capture;
    logic        clock_in = 1'b0;
    logic        resetn_in;
    logic        enable_in;
    logic        ir_in;
    logic        ready_in;

    logic [15:0] a_data, b_data, c_data;
    logic        a_valid, b_valid, c_valid;
    logic        a_busy, b_busy, c_busy;
    logic        a_fe, b_fe, c_fe;
    logic        a_ovf, b_ovf, c_ovf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          mark_cyc;
        int          space_cyc;
        logic [15:0] exp_mark;
        logic [15:0] exp_space;
    } vec_t;

    vec_t vecs[5];

    always #5 clock_in = ~clock_in;

    ir_pulse_capture #(.TICK_DIV(8), .FIFO_DEPTH(16), .TIMEOUT_TICKS(100)) dut_a (
        .clock_in(clock_in), .resetn_in(resetn_in), .enable_in(enable_in), .ir_in(ir_in),
        .data_out(a_data), .valid_out(a_valid), .ready_in(ready_in), .busy_out(a_busy),
        .frame_end_out(a_fe), .overflow_out(a_ovf));

    ir_pulse_capture #(.TICK_DIV(8), .FIFO_DEPTH(16), .TIMEOUT_TICKS(2000)) dut_b (
        .clock_in(clock_in), .resetn_in(resetn_in), .enable_in(enable_in), .ir_in(ir_in),
        .data_out(b_data), .valid_out(b_valid), .ready_in(ready_in), .busy_out(b_busy),
        .frame_end_out(b_fe), .overflow_out(b_ovf));

    ir_pulse_capture #(.TICK_DIV(1), .FIFO_DEPTH(4), .TIMEOUT_TICKS(2000)) dut_c (
        .clock_in(clock_in), .resetn_in(resetn_in), .enable_in(enable_in), .ir_in(ir_in),
        .data_out(c_data), .valid_out(c_valid), .ready_in(ready_in), .busy_out(c_busy),
        .frame_end_out(c_fe), .overflow_out(c_ovf));

    function automatic logic sel_valid(input int inst);
        case (inst)
            0:       return a_valid;
            1:       return b_valid;
            default: return c_valid;
        endcase
    endfunction

    function automatic logic [15:0] sel_data(input int inst);
        case (inst)
            0:       return a_data;
            1:       return b_data;
            default: return c_data;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic apply_stimulus(input logic level, input int n);
        ir_in = level;
        cycles(n);
    endtask

    task automatic do_reset();
        resetn_in = 1'b0;
        ir_in     = 1'b1;
        ready_in  = 1'b0;
        cycles(3);
        resetn_in = 1'b1;
        cycles(2);
    endtask

    // Waits for an entry, checks it holds steady while stalled, then pops exactly one.
    task automatic pop_expect(input int inst, input logic [15:0] expected, input string name);
        int waited = 0;
        while (!sel_valid(inst) && waited < 2000) begin
            cycles(1);
            waited++;
        end
        if (!sel_valid(inst)) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL %s: no entry within 2000 cycles, expected %h", name, expected);
        end else begin
            check_output(name, sel_data(inst), expected);
            cycles(2);
            check_output({name, "_hold"}, {15'd0, sel_valid(inst)} == 16'd1 ? sel_data(inst) : 16'hDEAD, expected);
            ready_in = 1'b1;
            cycles(1);
            ready_in = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] exp_q[$];
        int          fe_count;
        int          vcount;
        logic [15:0] seen;

        vecs[0] = '{40,  20,  16'h8005, 16'h0002};
        vecs[1] = '{8,   15,  16'h8001, 16'h0001};
        vecs[2] = '{100, 7,   16'h800C, 16'h0000};
        vecs[3] = '{23,  799, 16'h8002, 16'h0063};
        vecs[4] = '{7,   64,  16'h8000, 16'h0008};

        enable_in = 1'b1;
        ir_in     = 1'b1;
        ready_in  = 1'b0;
        resetn_in = 1'b0;
        cycles(3);
        check_output("rst_valid", {15'd0, a_valid}, 16'd0);
        check_output("rst_busy",  {15'd0, a_busy},  16'd0);
        check_output("rst_fe",    {15'd0, a_fe},    16'd0);
        check_output("rst_ovf",   {15'd0, a_ovf},   16'd0);
        check_output("rst_data",  a_data,           16'd0);
        resetn_in = 1'b1;
        cycles(5);

        for (int v = 0; v < 5; v++) begin
            apply_stimulus(1'b0, vecs[v].mark_cyc);
            check_output($sformatf("vec%0d_busy_in_frame", v), {15'd0, a_busy}, 16'd1);
            apply_stimulus(1'b1, vecs[v].space_cyc);
            apply_stimulus(1'b0, 16);
            ir_in    = 1'b1;
            fe_count = 0;
            for (int i = 0; i < 1000; i++) begin
                cycles(1);
                if (a_fe) fe_count++;
            end
            check_output($sformatf("vec%0d_frame_end_count", v), 16'(fe_count), 16'd1);
            check_output($sformatf("vec%0d_busy_after", v), {15'd0, a_busy}, 16'd0);
            pop_expect(0, vecs[v].exp_mark,  $sformatf("vec%0d_mark", v));
            pop_expect(0, vecs[v].exp_space, $sformatf("vec%0d_space", v));
            pop_expect(0, 16'h8002,          $sformatf("vec%0d_tail_mark", v));
            pop_expect(0, 16'h0064,          $sformatf("vec%0d_timeout", v));
            pop_expect(0, 16'h0000,          $sformatf("vec%0d_term", v));
        end

        do_reset();
        apply_stimulus(1'b0, 80);
        apply_stimulus(1'b1, 200);
        apply_stimulus(1'b0, 2);
        apply_stimulus(1'b1, 200);
        apply_stimulus(1'b0, 40);
        apply_stimulus(1'b1, 1000);
`ifdef IR_RX_GLITCH_FILTER_EN
        exp_q = '{16'h800A, 16'h0032, 16'h8005, 16'h0064, 16'h0000};
`else
        exp_q = '{16'h800A, 16'h0019, 16'h8000, 16'h0019, 16'h8005, 16'h0064, 16'h0000};
`endif
        foreach (exp_q[i]) pop_expect(0, exp_q[i], $sformatf("glitch2_e%0d", i));
        check_output("glitch2_drained", {15'd0, a_valid}, 16'd0);

        apply_stimulus(1'b0, 80);
        apply_stimulus(1'b1, 200);
        apply_stimulus(1'b0, 6);
        apply_stimulus(1'b1, 200);
        apply_stimulus(1'b0, 40);
        apply_stimulus(1'b1, 1000);
        exp_q = '{16'h800A, 16'h0019, 16'h8000, 16'h0019, 16'h8005, 16'h0064, 16'h0000};
        foreach (exp_q[i]) pop_expect(0, exp_q[i], $sformatf("glitch6_e%0d", i));
        check_output("glitch6_drained", {15'd0, a_valid}, 16'd0);

        do_reset();
        ready_in = 1'b1;
        apply_stimulus(1'b0, 16);
        ir_in  = 1'b1;
        vcount = 0;
        seen   = 16'hFFFF;
        for (int i = 0; i < 30; i++) begin
            cycles(1);
            if (a_valid) begin
                vcount++;
                seen = a_data;
            end
        end
        ready_in = 1'b0;
        check_output("fwft_valid_cycles", 16'(vcount), 16'd1);
        check_output("fwft_data", seen, 16'h8002);

        do_reset();
        for (int k = 0; k <= 20; k++) apply_stimulus((k % 2 == 0) ? 1'b0 : 1'b1, 8 * (k + 1));
        enable_in = 1'b0;
        cycles(2);
        ir_in = 1'b1;
        cycles(10);
        check_output("ovf_set", {15'd0, a_ovf}, 16'd1);
        for (int k = 0; k < 16; k++)
            pop_expect(0, ((k % 2 == 0) ? 16'h8000 : 16'h0000) | 16'(k + 1), $sformatf("ovf_e%0d", k));
        check_output("ovf_drained", {15'd0, a_valid}, 16'd0);
        check_output("ovf_sticky", {15'd0, a_ovf}, 16'd1);
        enable_in = 1'b1;
        do_reset();
        check_output("ovf_cleared", {15'd0, a_ovf}, 16'd0);

        apply_stimulus(1'b0, 40);
        apply_stimulus(1'b1, 40);
        apply_stimulus(1'b0, 50);
        check_output("pre_rst_valid", {15'd0, a_valid}, 16'd1);
        check_output("pre_rst_busy",  {15'd0, a_busy},  16'd1);
        resetn_in = 1'b0;
        cycles(1);
        check_output("mid_rst_valid", {15'd0, a_valid}, 16'd0);
        check_output("mid_rst_busy",  {15'd0, a_busy},  16'd0);
        resetn_in = 1'b1;
        ir_in     = 1'b1;
        cycles(1000);
        check_output("post_rst_no_entry", {15'd0, a_valid}, 16'd0);
        check_output("post_rst_idle",     {15'd0, a_busy},  16'd0);

        do_reset();
        apply_stimulus(1'b0, 4480);
        apply_stimulus(1'b1, 4480);
        apply_stimulus(1'b0, 100);
        enable_in = 1'b0;
        cycles(3);
        ir_in = 1'b1;
        pop_expect(1, 16'h8230, "long_mark");
        pop_expect(1, 16'h0230, "long_space");
        check_output("long_drained", {15'd0, b_valid}, 16'd0);
        enable_in = 1'b1;

        do_reset();
        apply_stimulus(1'b0, 33000);
        check_output("sat_busy",     {15'd0, c_busy},  16'd1);
        check_output("sat_no_entry", {15'd0, c_valid}, 16'd0);
        apply_stimulus(1'b1, 50);
        pop_expect(2, 16'hFFFF, "sat_entry");
        check_output("sat_drained", {15'd0, c_valid}, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1500000;
        n_errors++;
        $display("[TB] FAIL watchdog: time limit reached before completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
